// File: rtl/scn_ram_slot_arbiter.sv
// SCN RAM time-division slot arbiter: 8 addr/data pairs per 16-tick column.
// Define SCN_BLANK_CPU_EN to let the CPU take any pair during blanking.
module scn_ram_slot_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int CPU_PAIR = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce_13m,
  input  logic          line_start,
  input  logic          vid_blank,
  input  logic [AW-1:0] vid_addr,
  output logic [3:0]    slot,
  output logic          vid_strobe,
  output logic [DW-1:0] vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-2:0] ram_addr,
  output logic          ram_cs0_n,
  output logic          ram_cs1_n,
  output logic          ram_we_hi_n,
  output logic          ram_we_lo_n,
  output logic [DW-1:0] ram_dout,
  input  logic [DW-1:0] ram_din
);

`ifdef SCN_BLANK_CPU_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic [AW-1:0] addr_q;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [1:0]    c_be;
  logic          c_we;
  logic          pending;
  logic          busy;
  logic          armed;

  logic [3:0]    slot_nxt;
  logic [2:0]    pair_n;
  logic          addr_ph;
  logic          cpu_slot;
  logic          accept;
  logic          pend_eff;
  logic          take;
  logic [AW-1:0] e_addr;
  logic [1:0]    e_be;
  logic          e_we;

  // A request accepted on this tick is forwarded straight into the commit.
  always_comb begin
    slot_nxt = line_start ? 4'd0 : slot + 4'd1;
    addr_ph  = ~slot_nxt[0];
    pair_n   = slot_nxt[3:1];
    cpu_slot = (pair_n == 3'(CPU_PAIR));
    accept   = cpu_req & armed & ~pending;
    pend_eff = pending | accept;
    e_addr   = accept ? cpu_addr : c_addr;
    e_be     = accept ? cpu_be : c_be;
    e_we     = accept ? cpu_we : c_we;
    take     = addr_ph & pend_eff &
               (cpu_slot | (BLANK_EN & vid_blank & slot[0]));
  end

  assign ram_addr  = addr_q[AW-2:0];
  assign ram_cs0_n = addr_q[AW-1];
  assign ram_cs1_n = ~addr_q[AW-1];
  assign ram_dout  = c_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot        <= '0;
      addr_q      <= '0;
      c_addr      <= '0;
      c_wdata     <= '0;
      c_be        <= '0;
      c_we        <= 1'b0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      armed       <= 1'b1;
      vid_strobe  <= 1'b0;
      vid_data    <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      ram_we_hi_n <= 1'b1;
      ram_we_lo_n <= 1'b1;
    end else if (ce_13m) begin
      slot        <= slot_nxt;
      vid_strobe  <= 1'b0;
      cpu_ack     <= 1'b0;
      ram_we_hi_n <= 1'b1;
      ram_we_lo_n <= 1'b1;
      if (!cpu_req)
        armed <= 1'b1;
      if (accept) begin
        pending <= 1'b1;
        armed   <= 1'b0;
        c_addr  <= cpu_addr;
        c_wdata <= cpu_wdata;
        c_be    <= cpu_be;
        c_we    <= cpu_we;
      end
      // line_start lands here too: an in-flight CPU pair is dropped.
      if (addr_ph) begin
        busy <= take;
        if (take) begin
          addr_q <= e_addr;
          if (e_we) begin
            ram_we_hi_n <= ~e_be[1];
            ram_we_lo_n <= ~e_be[0];
          end
        end else if (!cpu_slot) begin
          addr_q <= vid_addr;
        end
      end else if (busy) begin
        cpu_ack <= 1'b1;
        busy    <= 1'b0;
        pending <= 1'b0;
        if (!c_we)
          cpu_rdata <= ram_din;
      end else if (slot[3:1] != 3'(CPU_PAIR)) begin
        vid_strobe <= 1'b1;
        vid_data   <= ram_din;
      end
    end
  end

endmodule

// File: tb/tb_scn_ram_slot_arbiter.sv
// Directed bench for scn_ram_slot_arbiter: vector table plus corner sequences.
// RAM model returns {cs1_n, addr} ^ 16'h5A5A, with 0xBEEF at bank 1 word 0x0123.
module tb_scn_ram_slot_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_13m;
  logic        line_start;
  logic        vid_blank;
  logic [15:0] vid_addr;
  logic [3:0]  slot;
  logic        vid_strobe;
  logic [15:0] vid_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [14:0] ram_addr;
  logic        ram_cs0_n;
  logic        ram_cs1_n;
  logic        ram_we_hi_n;
  logic        ram_we_lo_n;
  logic [15:0] ram_dout;
  logic [15:0] ram_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign vid_addr = {12'h400, slot};

  always_comb begin
    if (!ram_cs1_n && ram_addr == 15'h0123)
      ram_din = 16'hBEEF;
    else
      ram_din = {ram_cs1_n, ram_addr} ^ 16'h5A5A;
  end

  scn_ram_slot_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce_13m      (ce_13m),
    .line_start  (line_start),
    .vid_blank   (vid_blank),
    .vid_addr    (vid_addr),
    .slot        (slot),
    .vid_strobe  (vid_strobe),
    .vid_data    (vid_data),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_be      (cpu_be),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .ram_addr    (ram_addr),
    .ram_cs0_n   (ram_cs0_n),
    .ram_cs1_n   (ram_cs1_n),
    .ram_we_hi_n (ram_we_hi_n),
    .ram_we_lo_n (ram_we_lo_n),
    .ram_dout    (ram_dout),
    .ram_din     (ram_din)
  );

  typedef struct {
    logic        req;
    logic [3:0]  e_slot;
    logic        e_ack;
    logic        e_stb;
    logic [14:0] e_addr;
    logic        e_cs1;
    logic [15:0] e_rdata;
    logic [15:0] e_vdata;
  } vec_t;

  vec_t tv[18];

  function automatic vec_t row(input logic r, input logic [3:0] s,
                               input logic a, input logic st,
                               input logic [14:0] ad, input logic c1,
                               input logic [15:0] rd, input logic [15:0] vd);
    vec_t v;
    v.req = r; v.e_slot = s; v.e_ack = a; v.e_stb = st;
    v.e_addr = ad; v.e_cs1 = c1; v.e_rdata = rd; v.e_vdata = vd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_slot(input logic [3:0] s);
    for (int n = 0; n < 40 && slot != s; n++)
      step();
    chk("wait_slot", {28'd0, slot}, {28'd0, s});
  endtask

  task automatic wait_ack(input int max, output int n);
    n = 0;
    while (!cpu_ack && n < max) begin
      step();
      n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks;
    tv[0]  = row(0, 1,  0, 1, 15'h0000, 1, 16'h0000, 16'hDA5A);
    tv[1]  = row(0, 2,  0, 0, 15'h4001, 1, 16'h0000, 16'hDA5A);
    tv[2]  = row(1, 3,  0, 1, 15'h4001, 1, 16'h0000, 16'h9A5B);
    tv[3]  = row(1, 4,  0, 0, 15'h4003, 1, 16'h0000, 16'h9A5B);
    tv[4]  = row(1, 5,  0, 1, 15'h4003, 1, 16'h0000, 16'h9A59);
    tv[5]  = row(1, 6,  0, 0, 15'h4005, 1, 16'h0000, 16'h9A59);
    tv[6]  = row(1, 7,  0, 1, 15'h4005, 1, 16'h0000, 16'h9A5F);
    tv[7]  = row(1, 8,  0, 0, 15'h4007, 1, 16'h0000, 16'h9A5F);
    tv[8]  = row(1, 9,  0, 1, 15'h4007, 1, 16'h0000, 16'h9A5D);
    tv[9]  = row(1, 10, 0, 0, 15'h4009, 1, 16'h0000, 16'h9A5D);
    tv[10] = row(1, 11, 0, 1, 15'h4009, 1, 16'h0000, 16'h9A53);
    tv[11] = row(1, 12, 0, 0, 15'h400B, 1, 16'h0000, 16'h9A53);
    tv[12] = row(1, 13, 0, 1, 15'h400B, 1, 16'h0000, 16'h9A51);
    tv[13] = row(1, 14, 0, 0, 15'h0123, 0, 16'h0000, 16'h9A51);
    tv[14] = row(1, 15, 1, 0, 15'h0123, 0, 16'hBEEF, 16'h9A51);
    tv[15] = row(1, 0,  0, 0, 15'h400F, 1, 16'hBEEF, 16'h9A51);
    tv[16] = row(0, 1,  0, 1, 15'h400F, 1, 16'hBEEF, 16'h9A55);
    tv[17] = row(0, 2,  0, 0, 15'h4001, 1, 16'hBEEF, 16'h9A55);

    reset_n = 1'b0; ce_13m = 1'b1; line_start = 1'b0; vid_blank = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00;
    cpu_addr = 16'h8123; cpu_wdata = 16'h0000;
    repeat (3) step();

    chk("rst_slot", {28'd0, slot}, 32'd0);
    chk("rst_addr", {17'd0, ram_addr}, 32'd0);
    chk("rst_cs0", {31'd0, ram_cs0_n}, 32'd0);
    chk("rst_cs1", {31'd0, ram_cs1_n}, 32'd1);
    chk("rst_wehi", {31'd0, ram_we_hi_n}, 32'd1);
    chk("rst_welo", {31'd0, ram_we_lo_n}, 32'd1);
    chk("rst_dout", {16'd0, ram_dout}, 32'd0);
    chk("rst_stb", {31'd0, vid_strobe}, 32'd0);
    chk("rst_vdata", {16'd0, vid_data}, 32'd0);
    chk("rst_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cpu_req = tv[i].req;
      step();
      chk($sformatf("v%0d_slot", i), {28'd0, slot}, {28'd0, tv[i].e_slot});
      chk($sformatf("v%0d_ack", i), {31'd0, cpu_ack}, {31'd0, tv[i].e_ack});
      chk($sformatf("v%0d_stb", i), {31'd0, vid_strobe}, {31'd0, tv[i].e_stb});
      chk($sformatf("v%0d_addr", i), {17'd0, ram_addr}, {17'd0, tv[i].e_addr});
      chk($sformatf("v%0d_cs1", i), {31'd0, ram_cs1_n}, {31'd0, tv[i].e_cs1});
      chk($sformatf("v%0d_cs0", i), {31'd0, ram_cs0_n}, {31'd0, ~tv[i].e_cs1});
      chk($sformatf("v%0d_we", i), {30'd0, ram_we_hi_n, ram_we_lo_n}, 32'd3);
      chk($sformatf("v%0d_rdata", i), {16'd0, cpu_rdata}, {16'd0, tv[i].e_rdata});
      chk($sformatf("v%0d_vdata", i), {16'd0, vid_data}, {16'd0, tv[i].e_vdata});
    end

    // write with upper byte only, raised at slot 12
    wait_slot(12);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b10;
    cpu_addr = 16'h0456; cpu_wdata = 16'h12AB;
    step();
    chk("wr13_wehi", {31'd0, ram_we_hi_n}, 32'd1);
    step();
    chk("wr14_wehi", {31'd0, ram_we_hi_n}, 32'd0);
    chk("wr14_welo", {31'd0, ram_we_lo_n}, 32'd1);
    chk("wr14_dout", {16'd0, ram_dout}, 32'h12AB);
    chk("wr14_addr", {17'd0, ram_addr}, 32'h0456);
    chk("wr14_cs1", {31'd0, ram_cs1_n}, 32'd1);
    step();
    chk("wr15_ack", {31'd0, cpu_ack}, 32'd1);
    chk("wr15_wehi", {31'd0, ram_we_hi_n}, 32'd1);
    chk("wr15_rdata", {16'd0, cpu_rdata}, 32'hBEEF);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00;
    step();
    chk("wr0_ack", {31'd0, cpu_ack}, 32'd0);

    // read raised after the commit: waits a full column
    wait_slot(14);
    cpu_req = 1'b1; cpu_addr = 16'h0010;
    wait_ack(40, n);
    chk("late_ticks", n, 32'd17);
    chk("late_slot", {28'd0, slot}, 32'd15);
    chk("late_rdata", {16'd0, cpu_rdata}, 32'hDA4A);

    // held request never re-issues
    acks = 0;
    repeat (40) begin
      step();
      if (cpu_ack) acks++;
    end
    chk("held_acks", acks, 32'd0);
    cpu_req = 1'b0;
    step();
    cpu_req = 1'b1;
    wait_ack(40, n);
    chk("rearm_ack", {31'd0, cpu_ack}, 32'd1);
    cpu_req = 1'b0;
    step();

    // one-tick request, then line_start cuts the busy CPU pair
    wait_slot(2);
    cpu_req = 1'b1; cpu_addr = 16'h0200;
    step();
    cpu_req = 1'b0;
    wait_slot(14);
    chk("ls14_addr", {17'd0, ram_addr}, 32'h0200);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    chk("ls_slot", {28'd0, slot}, 32'd0);
    chk("ls_ack", {31'd0, cpu_ack}, 32'd0);
    chk("ls_we", {30'd0, ram_we_hi_n, ram_we_lo_n}, 32'd3);
    wait_ack(40, n);
    chk("ls_retry_ticks", n, 32'd15);
    chk("ls_retry_rdata", {16'd0, cpu_rdata}, 32'hD85A);

    // line_start inside a video pair suppresses its strobe
    wait_slot(4);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    chk("cut_slot", {28'd0, slot}, 32'd0);
    chk("cut_stb", {31'd0, vid_strobe}, 32'd0);
    step();
    chk("pair0_stb", {31'd0, vid_strobe}, 32'd1);

    // no tick enable, no advance
    ce_13m = 1'b0;
    repeat (3) step();
    chk("ce_hold", {28'd0, slot}, 32'd1);
    ce_13m = 1'b1;

    // reset mid-operation drops the request
    wait_slot(2);
    cpu_req = 1'b1; cpu_addr = 16'h0300;
    step();
    cpu_req = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    chk("mid_rst_slot", {28'd0, slot}, 32'd0);
    chk("mid_rst_addr", {17'd0, ram_addr}, 32'd0);
    reset_n = 1'b1;
    acks = 0;
    repeat (20) begin
      step();
      if (cpu_ack) acks++;
    end
    chk("mid_rst_acks", acks, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
